l1_beat_packer: RTL and testbench

Sink stage that sits directly downstream of the `l1_if.slave` modport. It consumes the 1-bit `data`/`valid` beat stream a producer drives onto `l1_if.master`. Beats are packed LSB-first into `WIDTH`-bit words and each word is stamped with the parent `l2_if` ID tag and a wrapping sequence number. Words are presented on a valid/ready output through a small FIFO. The `l1_if` stream has no backpressure, so words that arrive while the FIFO is full are dropped and counted.

---
 rtl/l1_beat_packer_if.sv | 25 ++
 rtl/l1_beat_packer.sv | 125 ++++++++++++
 tb/tb_l1_beat_packer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_beat_packer_if.sv
// Bundle of the beat stream in, the packed-word stream out and the drop status.
// The producer/consumer side uses master; the packer uses slave.
interface l1_beat_packer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_data;
    logic             in_valid;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [3:0]       out_tag;
    logic [3:0]       out_seq;
    logic [7:0]       drop_cnt;
    logic             overflow;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_valid, out_word, out_tag, out_seq, drop_cnt, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_valid, out_word, out_tag, out_seq, drop_cnt, overflow
    );
endinterface

// File: rtl/l1_beat_packer.sv
// Packs a 1-bit beat stream LSB-first into WIDTH-bit words, tags each word
// with a wrapping 4-bit sequence number and queues it in a small FIFO.
// The beat stream cannot be stalled, so words arriving to a full FIFO are
// dropped and counted.
module l1_beat_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int ID    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    l1_beat_packer_if.slave     bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       seq;
        logic [WIDTH-1:0] word;
    } entry_t;

    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] pack_q, pack_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [3:0]       seq_q, seq_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic word_done;
    logic pop;
    logic push_ok;

    // Next-state: beat shifting, word completion, FIFO push/pop and drop accounting.
    always_comb begin
        bit_idx_d  = bit_idx_q;
        pack_d     = pack_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        word_done  = 1'b0;

        if (bus.in_valid) begin
            pack_d[bit_idx_q] = bus.in_data;
            if (bit_idx_q == IW'(WIDTH - 1)) begin
                word_done = 1'b1;
                bit_idx_d = '0;
            end else begin
                bit_idx_d = bit_idx_q + IW'(1);
            end
        end

        pop = (count_q != '0) && bus.out_ready;
        // A full FIFO can still take the word if the head leaves this cycle.
        push_ok = word_done && ((count_q != (AW+1)'(DEPTH)) || pop);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = '{seq: seq_q, word: pack_d};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            seq_d           = seq_q + 4'd1;
        end

        if (push_ok && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (AW+1)'(1);
        end

        // Refused words do not take a sequence number.
        if (word_done && !push_ok) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset discards any partial word and empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_idx_q  <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            bit_idx_q  <= bit_idx_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs come straight from registers; nothing from in_* reaches them combinationally.
    assign bus.out_valid = (count_q != '0);
    assign bus.out_word  = mem_q[rd_ptr_q].word;
    assign bus.out_seq   = mem_q[rd_ptr_q].seq;
    assign bus.out_tag   = 4'(ID);
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_l1_beat_packer.sv
// Bench for l1_beat_packer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_l1_beat_packer;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int ID = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l1_beat_packer_if #(.WIDTH(W)) bus ();

    l1_beat_packer #(.WIDTH(W), .DEPTH(D), .ID(ID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit en_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit accumulator and a bounded queue of {seq, word}.
    typedef struct packed {
        logic [3:0]   seq;
        logic [W-1:0] word;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] macc;
    int           mbits;
    int           mseq;
    int           mdrops;

    always @(posedge clk) begin
        ent_t e;
        bit   complete;
        if (!rst_n) begin
            mq.delete();
            macc   = '0;
            mbits  = 0;
            mseq   = 0;
            mdrops = 0;
        end else begin
            complete = 1'b0;
            if (bus.in_valid) begin
                macc[mbits] = bus.in_data;
                mbits++;
                if (mbits == W) begin
                    complete = 1'b1;
                    mbits    = 0;
                end
            end
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (complete) begin
                if (mq.size() < D) begin
                    e.seq  = 4'(mseq);
                    e.word = macc;
                    mq.push_back(e);
                    mseq = (mseq + 1) % 16;
                end else begin
                    mdrops++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of popped sequence numbers.
    logic [3:0] pop_log[$];
    always @(negedge clk) begin
        if (en_cmp) begin
            chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_out_word", 32'(bus.out_word), 32'(mq[0].word));
                chk("m_out_seq", 32'(bus.out_seq), 32'(mq[0].seq));
            end
            chk("m_drop_cnt", 32'(bus.drop_cnt), (mdrops > 255) ? 32'd255 : 32'(mdrops));
            chk("m_overflow", 32'(bus.overflow), 32'(mdrops > 0));
            chk("m_out_tag", 32'(bus.out_tag), 32'(ID % 16));
            if (bus.out_valid && bus.out_ready) pop_log.push_back(bus.out_seq);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) beat(w[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    logic       a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] w77;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        idle(2);
        rst_n  = 1'b1;
        en_cmp = 1'b1;

        // Reset values
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", 32'(bus.out_word), 32'd0);
        chk("rst_out_seq", 32'(bus.out_seq), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd1);

        // Back-to-back beats of 0xA5
        for (int i = 0; i < 8; i++) begin
            beat(a5_bits[i]);
            if (i < 7) chk("a5_no_early", 32'(bus.out_valid), 32'd0);
        end
        chk("a5_valid", 32'(bus.out_valid), 32'd1);
        chk("a5_word", 32'(bus.out_word), 32'hA5);
        chk("a5_seq", 32'(bus.out_seq), 32'd0);
        chk("a5_tag", 32'(bus.out_tag), 32'd1);
        idle(1);
        chk("a5_popped", 32'(bus.out_valid), 32'd0);

        // Same word with random idle gaps between beats
        for (int i = 0; i < 8; i++) begin
            beat(a5_bits[i]);
            if (i < 7) begin
                chk("gap_no_early", 32'(bus.out_valid), 32'd0);
                repeat ($urandom_range(0, 3)) begin
                    idle(1);
                    chk("gap_idle_no_word", 32'(bus.out_valid), 32'd0);
                end
            end
        end
        chk("gap_valid", 32'(bus.out_valid), 32'd1);
        chk("gap_word", 32'(bus.out_word), 32'hA5);
        chk("gap_seq", 32'(bus.out_seq), 32'd1);
        idle(1);

        // Stall: two words retained, third dropped
        do_reset();
        bus.out_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_head_word", 32'(bus.out_word), 32'h11);
        chk("stall_head_seq", 32'(bus.out_seq), 32'd0);
        chk("stall_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("stall_overflow", 32'(bus.overflow), 32'd1);
        bus.out_ready = 1'b1;
        idle(1);
        chk("release_word2", 32'(bus.out_word), 32'h22);
        chk("release_seq2", 32'(bus.out_seq), 32'd1);
        idle(1);
        chk("release_empty", 32'(bus.out_valid), 32'd0);
        send_word(8'h44);
        chk("after_drop_word", 32'(bus.out_word), 32'h44);
        chk("after_drop_seq", 32'(bus.out_seq), 32'd2);
        idle(1);

        // Full FIFO with a pop on the edge a word completes
        bus.out_ready = 1'b0;
        send_word(8'h55);
        send_word(8'h66);
        w77 = 8'h77;
        for (int i = 0; i < 7; i++) beat(w77[i]);
        bus.out_ready = 1'b1;
        beat(w77[7]);
        bus.out_ready = 1'b0;
        chk("full_pop_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("full_pop_head", 32'(bus.out_word), 32'h66);
        chk("full_pop_head_seq", 32'(bus.out_seq), 32'd4);
        idle(1);
        chk("full_pop_stable", 32'(bus.out_word), 32'h66);
        bus.out_ready = 1'b1;
        idle(1);
        chk("full_pop_next", 32'(bus.out_word), 32'h77);
        chk("full_pop_next_seq", 32'(bus.out_seq), 32'd5);
        idle(1);
        chk("full_pop_empty", 32'(bus.out_valid), 32'd0);

        // Partial word discarded by reset; beats during reset ignored
        for (int i = 0; i < 4; i++) beat(1'b1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        idle(1);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        send_word(8'h3C);
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd1);
        chk("rst_mid_word", 32'(bus.out_word), 32'h3C);
        chk("rst_mid_seq", 32'(bus.out_seq), 32'd0);
        chk("rst_mid_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("rst_mid_overflow", 32'(bus.overflow), 32'd0);
        idle(2);

        // Sequence wrap over 17 words
        do_reset();
        pop_log.delete();
        for (int i = 0; i < 17; i++) send_word(8'(i * 7 + 1));
        idle(2);
        chk("wrap_count", 32'(pop_log.size()), 32'd17);
        for (int i = 0; i < 17 && i < pop_log.size(); i++) begin
            chk("wrap_seq", 32'(pop_log[i]), 32'(i % 16));
        end

        // Drop counter saturation
        bus.out_ready = 1'b0;
        for (int i = 0; i < 302; i++) send_word(8'(i));
        chk("sat_drop_cnt", 32'(bus.drop_cnt), 32'd255);
        chk("sat_overflow", 32'(bus.overflow), 32'd1);
        chk("sat_valid", 32'(bus.out_valid), 32'd1);
        chk("sat_head_word", 32'(bus.out_word), 32'h00);

        en_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
